// File: rtl/fpu_div_seq.sv
// Issue/sequencing stage in front of the combinational fp_div.
// Holds operands for LATENCY cycles, then applies IEEE special-case overrides.
module fpu_div_seq #(
  parameter int TAG_W   = 5,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_rd,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic [31:0]      div_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic [4:0]       rsp_fflags,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  FL_NV    = 5'b10000;
  localparam logic [4:0]  FL_DZ    = 5'b01000;

  state_t      state;
  logic [3:0]  cnt;
  logic        spec_hit;
  logic [31:0] spec_data;
  logic [4:0]  spec_flags;

  logic        a_nan, b_nan, a_snan, b_snan;
  logic        a_inf, b_inf, a_zero, b_zero;
  logic        sgn;
  logic        hit_d;
  logic [31:0] data_d;
  logic [4:0]  flags_d;

  assign a_nan  = (req_a[30:23] == 8'hFF) && (req_a[22:0] != 23'h0);
  assign b_nan  = (req_b[30:23] == 8'hFF) && (req_b[22:0] != 23'h0);
  assign a_snan = a_nan && !req_a[22];
  assign b_snan = b_nan && !req_b[22];
  assign a_inf  = (req_a[30:23] == 8'hFF) && (req_a[22:0] == 23'h0);
  assign b_inf  = (req_b[30:23] == 8'hFF) && (req_b[22:0] == 23'h0);
  assign a_zero = (req_a[30:0] == 31'h0);
  assign b_zero = (req_b[30:0] == 31'h0);
  assign sgn    = req_a[31] ^ req_b[31];

  // Arms are ordered: later arms may assume earlier ones failed.
  always_comb begin
    hit_d   = 1'b1;
    data_d  = QNAN;
    flags_d = 5'b0;
    priority case (1'b1)
      a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf):
        flags_d = FL_NV;
      a_nan || b_nan: ;
      a_inf:
        data_d = {sgn, 8'hFF, 23'h0};
      b_zero: begin
        data_d  = {sgn, 8'hFF, 23'h0};
        flags_d = FL_DZ;
      end
      b_inf || a_zero:
        data_d = {sgn, 31'h0};
      default:
        hit_d = 1'b0;
    endcase
  end

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      div_a      <= 32'h0;
      div_b      <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'h0;
      rsp_rd     <= '0;
      rsp_fflags <= 5'b0;
      spec_hit   <= 1'b0;
      spec_data  <= 32'h0;
      spec_flags <= 5'b0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            div_a      <= req_a;
            div_b      <= req_b;
            rsp_rd     <= req_rd;
            spec_hit   <= hit_d;
            spec_data  <= data_d;
            spec_flags <= flags_d;
            cnt        <= CNT_INIT;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data   <= spec_hit ? spec_data : div_result;
            rsp_fflags <= spec_flags;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
